uart_tx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 82 ++++++++
 rtl/uart_tx_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the configurable UART blocks (uart_tx_cfg and the
// future uart_rx_cfg):
//   - parity mode encodings carried on the 2-bit parity_mode field
//   - the frame FSM state enum
//   - a helper that tells whether a parity mode inserts a parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

  // Parity field encodings. Code 3 is reserved and behaves like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Frame sequencing states, in transmission order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // True when the mode adds a parity bit after the data bits.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with a registered occupancy count and show-ahead head.
//
// Parameters:
//   WIDTH  - entry width in bits
//   DEPTH  - number of entries, a power of two >= 2
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   i_push   in   write i_data this cycle
//   i_data   in   entry to write
//   i_pop    in   discard the head entry this cycle
//   o_head   out  current head entry (valid when o_empty is low)
//   o_full   out  FIFO holds DEPTH entries
//   o_empty  out  FIFO holds no entries
//   o_count  out  current occupancy, 0..DEPTH
//
// A push while full is accepted when a pop happens in the same cycle. A pop
// while empty is ignored, so a push into an empty FIFO always lands.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

  // Pointers are exactly AW bits wide, so incrementing past DEPTH-1 wraps to 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // define which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Buffered UART transmitter with a write FIFO, parametrised character width
// and run-time parity / stop-bit selection. Characters are sent LSB first.
//
// Parameters:
//   CLK_FREQ    - clock frequency in Hz
//   BAUD        - line rate; BIT_CLKS = CLK_FREQ / BAUD must be >= 2
//   DATA_BITS   - character width, 5..9
//   FIFO_DEPTH  - FIFO entries, a power of two >= 2
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   write_en     in   enqueue data this cycle
//   data         in   character to send
//   parity_mode  in   0 none, 1 even, 2 odd, 3 none
//   stop2        in   0 one stop bit, 1 two stop bits
//   tx           out  serial line, idles high
//   uart_busy    out  FIFO non-empty or a frame in progress
//   fifo_full    out  FIFO holds FIFO_DEPTH entries
//   fifo_count   out  FIFO occupancy
//   overflow     out  one-cycle pulse when a write is dropped
//   tx_done      out  high during the last clock of each frame's last stop bit
// -----------------------------------------------------------------------------
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic [DATA_BITS-1:0]          data,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          tx,
  output logic                          uart_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_done
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int BW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int CW       = $clog2(DATA_BITS);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BIT_CLKS - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_push_ok;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (write_en),
    .i_data  (data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Frame registers
  // ---------------------------------------------------------------------------
  uart_state_e          r_state;
  logic [BW-1:0]        r_baud;
  logic [CW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;
  logic                 r_stop_idx;
  logic                 r_tx;
  logic                 r_tx_done;
  logic                 r_busy;
  logic                 r_overflow;

  logic w_bit_end;
  logic w_last_stop;
  logic w_frame_end;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  // In the final stop bit: the only one with stop2 clear, the second with it set.
  assign w_last_stop = (r_state == ST_STOP) && (!r_stop2 || r_stop_idx);
  assign w_frame_end = w_last_stop && w_bit_end;

  // The head is taken whenever the line is free: from IDLE, or on the last
  // stop-bit clock so the next start bit follows with no idle gap.
  assign w_pop     = !w_fifo_empty && ((r_state == ST_IDLE) || w_frame_end);
  assign w_push_ok = write_en && (!w_fifo_full || w_pop);

  // ---------------------------------------------------------------------------
  // Frame FSM with registered tx, tx_done and uart_busy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Raised one clock early so the registered pulse lines up with the
      // final clock of the last stop bit.
      r_tx_done <= w_last_stop && (r_baud == BAUD_PRE);

      // The baud counter free-runs through a frame and wraps every bit period.
      r_baud <= w_bit_end ? '0 : r_baud + 1'b1;

      // Busy stays set unless the FSM settles in IDLE. Reaching IDLE implies the
      // FIFO is empty, so only a write accepted this cycle keeps busy high.
      r_busy <= 1'b1;

      if (w_pop) begin
        // Frame load: character and configuration are frozen for the frame.
        r_shift    <= w_head;
        r_par_en   <= parity_enabled(parity_mode);
        r_par_bit  <= (^w_head) ^ (parity_mode == PAR_ODD);
        r_stop2    <= stop2;
        r_stop_idx <= 1'b0;
        r_baud     <= '0;
        r_tx       <= 1'b0;
        r_state    <= ST_START;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_tx   <= 1'b1;
            r_baud <= '0;
            r_busy <= w_push_ok;
          end

          ST_START: begin
            if (w_bit_end) begin
              r_state   <= ST_DATA;
              r_tx      <= r_shift[0];
              r_bit_cnt <= '0;
            end
          end

          ST_DATA: begin
            if (w_bit_end) begin
              if (r_bit_cnt == BIT_LAST) begin
                if (r_par_en) begin
                  r_state <= ST_PARITY;
                  r_tx    <= r_par_bit;
                end else begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= r_shift >> 1;
                r_tx      <= r_shift[1];
              end
            end
          end

          ST_PARITY: begin
            if (w_bit_end) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end
          end

          ST_STOP: begin
            if (w_bit_end) begin
              if (w_last_stop) begin
                r_state <= ST_IDLE;
                r_busy  <= w_push_ok;
              end else begin
                r_stop_idx <= 1'b1;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  // A write is dropped only when the FIFO is full and no pop frees a slot.
  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= write_en && w_fifo_full && !w_pop;
  end

  assign tx        = r_tx;
  assign tx_done   = r_tx_done;
  assign uart_busy = r_busy;
  assign fifo_full = w_fifo_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Two instances at CLK_FREQ=16, BAUD=1 (16 clocks per bit): an 8-bit one with a
// 16-entry FIFO and a 5-bit one with a 4-entry FIFO. The stimulus thread pushes
// hand-written expected frames into per-instance queues; a monitor per
// instance decodes tx at mid-bit and compares whole frames, gaps and tx_done.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;
  import uart_pkg::*;

  localparam int BITC = 16;

  typedef struct {
    logic [15:0] bits;   // index 0 = start bit, then data LSB first, parity, stops
    int          len;    // bit periods in the frame
    bit          contig; // must start the clock after the previous frame ended
    int          tag;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  // 8-bit instance
  logic       we8, s28, tx8, busy8, full8, ovf8, done8;
  logic [7:0] d8;
  logic [1:0] pm8;
  logic [4:0] count8;
  // 5-bit instance
  logic       we5, s25, tx5, busy5, full5, ovf5, done5;
  logic [4:0] d5;
  logic [1:0] pm5;
  logic [2:0] count5;

  frame_t q8[$];
  frame_t q5[$];
  int checks = 0, failures = 0;
  int frames8 = 0, frames5 = 0, aborted8 = 0, aborted5 = 0;

  uart_tx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .FIFO_DEPTH(16)) dut8 (
    .clk(clk), .rst(rst), .write_en(we8), .data(d8), .parity_mode(pm8),
    .stop2(s28), .tx(tx8), .uart_busy(busy8), .fifo_full(full8),
    .fifo_count(count8), .overflow(ovf8), .tx_done(done8)
  );

  uart_tx_cfg #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
    .clk(clk), .rst(rst), .write_en(we5), .data(d5), .parity_mode(pm5),
    .stop2(s25), .tx(tx5), .uart_busy(busy5), .fifo_full(full5),
    .fifo_count(count5), .overflow(ovf5), .tx_done(done5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] bits, input int len,
                                input bit contig, input int tag);
    frame_t f;
    f.bits = bits; f.len = len; f.contig = contig; f.tag = tag;
    return f;
  endfunction

  // Frame monitor: runs on the negative edge, away from the active edge.
  task automatic monitor(input bit is5);
    frame_t      it;
    bit          in_frame = 1'b0;
    int          s = 0, last_end = -1000, done_n = 0, off = 0, qs = 0;
    logic [15:0] got = '0;
    logic        l_tx, l_done;
    string       nm;
    nm = is5 ? "dut5" : "dut8";
    forever begin
      @(negedge clk);
      l_tx   = is5 ? tx5 : tx8;
      l_done = is5 ? done5 : done8;
      if (rst) begin
        if (in_frame) begin
          if (is5) aborted5++; else aborted8++;
        end
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame && l_tx === 1'b0) begin
        qs = is5 ? q5.size() : q8.size();
        check({nm, "_frame_expected"}, 32'(qs != 0), 1);
        if (qs == 0)  it = mk('0, 10, 1'b0, -1);
        else if (is5) it = q5.pop_front();
        else          it = q8.pop_front();
        if (it.contig) check($sformatf("%s_gap_%0d", nm, it.tag), cyc - last_end, 1);
        in_frame = 1'b1; s = cyc; done_n = 0; got = '0;
      end
      if (in_frame) begin
        off = cyc - s;
        if (off % BITC == BITC/2) got[off/BITC] = l_tx;
        if (l_done === 1'b1) done_n++;
        if (off == BITC*it.len - 1) begin
          if (it.tag >= 0) begin
            check($sformatf("%s_frame_%0d", nm, it.tag), got, it.bits);
            check($sformatf("%s_done_last_clk_%0d", nm, it.tag), l_done, 1);
            check($sformatf("%s_done_count_%0d", nm, it.tag), done_n, 1);
            if (is5) frames5++; else frames8++;
          end
          in_frame = 1'b0;
          last_end = cyc;
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Bounded wait for an instance to go idle.
  task automatic wait_idle(input bit is5, input int budget, input string name);
    int n = 0;
    while ((is5 ? busy5 : busy8) !== 1'b0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check(name, is5 ? busy5 : busy8, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    we8 = 1'b0; d8 = '0; pm8 = PAR_NONE; s28 = 1'b0;
    we5 = 1'b0; d5 = '0; pm5 = PAR_NONE; s25 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx8, 1);
    check("rst_busy", busy8, 0);
    check("rst_full", full8, 0);
    check("rst_count", count8, 0);
    check("rst_overflow", ovf8, 0);
    check("rst_tx_done", done8, 0);
    check("rst_tx5", tx5, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0x55, no parity, one stop: 10 bits; busy from write edge through frame end.
    d8 = 8'h55; we8 = 1'b1;
    q8.push_back(mk(16'h02AA, 10, 1'b0, 1));
    @(posedge clk); #1;
    we8 = 1'b0;
    n = 0;
    while (busy8 === 1'b1 && n < 1000) begin n++; @(posedge clk); #1; end
    check("busy_len_55", n, 161);

    // 0x07 even parity (bit 1) then odd parity (bit 0), back to back.
    d8 = 8'h07; pm8 = PAR_EVEN; we8 = 1'b1;
    q8.push_back(mk(16'h060E, 11, 1'b0, 2));
    @(posedge clk); #1;
    we8 = 1'b0;
    @(posedge clk); #1;          // first frame loaded with even parity here
    pm8 = PAR_ODD; we8 = 1'b1;
    q8.push_back(mk(16'h040E, 11, 1'b1, 3));
    @(posedge clk); #1;
    we8 = 1'b0;
    wait_idle(1'b0, 800, "idle_after_parity");
    pm8 = PAR_NONE;

    // 18 consecutive writes 0x00..0x11: 17 fit (one popped at once), 18th drops.
    for (int i = 0; i < 18; i++) begin
      d8 = 8'(i); we8 = 1'b1;
      if (i < 17) q8.push_back(mk({6'd0, 1'b1, 8'(i), 1'b0}, 10, i != 0, 100 + i));
      @(posedge clk); #1;
      if (i == 0) begin
        check("lat_count", count8, 1);
        check("lat_tx_still_idle", tx8, 1);
      end
      if (i == 1) begin
        check("pop_count", count8, 1);
        check("lat_tx_start", tx8, 0);
      end
      if (i == 16) begin
        check("fill_count", count8, 16);
        check("fill_full", full8, 1);
        check("fill_no_overflow", ovf8, 0);
      end
      if (i == 17) begin
        check("drop_overflow", ovf8, 1);
        check("drop_count", count8, 16);
      end
    end
    we8 = 1'b0;
    @(posedge clk); #1;
    check("overflow_one_cycle", ovf8, 0);

    // Write while full in the same cycle as the pop at the end of frame 0x00.
    n = 0;
    while (done8 !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    check("wait_tx_done", done8, 1);
    d8 = 8'h12; we8 = 1'b1;
    q8.push_back(mk(16'h0224, 10, 1'b1, 117));
    @(posedge clk); #1;
    we8 = 1'b0;
    check("full_pop_count", count8, 16);
    check("full_pop_overflow", ovf8, 0);
    check("full_pop_full", full8, 1);
    wait_idle(1'b0, 4000, "idle_after_burst");
    check("frames8_sent", frames8, 21);

    // Reset 40 clocks into a frame with 3 bytes still queued.
    for (int i = 0; i < 4; i++) begin
      d8 = 8'h21 + 8'(i); we8 = 1'b1;
      if (i == 0) q8.push_back(mk(16'h0242, 10, 1'b0, 200));
      @(posedge clk); #1;
    end
    we8 = 1'b0;
    check("rst_pre_count", count8, 3);
    repeat (38) begin @(posedge clk); #1; end
    check("rst_pre_tx_low", tx8, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", tx8, 1);
    check("midrst_count", count8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_full", full8, 0);
    rst = 1'b0;
    n = 0;
    repeat (400) begin @(posedge clk); #1; if (tx8 !== 1'b1) n++; end
    check("midrst_no_more_frames", n, 0);
    check("midrst_busy_after", busy8, 0);
    check("midrst_aborted", aborted8, 1);

    // 5-bit instance: 0x1F, no parity, two stops; config toggled mid-frame.
    d5 = 5'h1F; pm5 = PAR_NONE; s25 = 1'b1; we5 = 1'b1;
    q5.push_back(mk(16'h00FE, 8, 1'b0, 1));
    @(posedge clk); #1;
    we5 = 1'b0;
    n = 0;
    while (busy5 === 1'b1 && n < 1000) begin
      n++;
      if (n == 50) begin pm5 = PAR_EVEN; s25 = 1'b0; end
      @(posedge clk); #1;
    end
    check("busy_len_1f", n, 129);

    // 0x0A, odd parity (bit 1), one stop.
    d5 = 5'h0A; pm5 = PAR_ODD; s25 = 1'b0; we5 = 1'b1;
    q5.push_back(mk(16'h00D4, 8, 1'b0, 2));
    @(posedge clk); #1;
    we5 = 1'b0;
    wait_idle(1'b1, 400, "idle_after_dut5");
    @(posedge clk); #1;
    check("frames5_sent", frames5, 2);
    check("q8_drained", q8.size(), 0);
    check("q5_drained", q5.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
